// File: rtl/cu_pkg.sv
// Shared types and constants for the control_unit_v2 controller.
package cu_pkg;

    // Controller states; encodings are visible on State_Out/Next_State.
    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        NOOP   = 4'd3,
        LOAD_A = 4'd4,
        LOAD_B = 4'd5,
        STORE  = 4'd6,
        ADD    = 4'd7,
        SUB    = 4'd8,
        HALT   = 4'd9,
        JMP    = 4'd10,
        BRZ    = 4'd11
    } state_t;

    // Opcodes carried in the top nibble of the instruction register.
    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_BRZ   = 4'd7;

    // ALU operation selects.
    localparam int unsigned ALU_PASS = 0;
    localparam int unsigned ALU_ADD  = 1;
    localparam int unsigned ALU_SUB  = 2;

endpackage

// File: rtl/cu_pc.sv
// Program counter: synchronous clear, parallel load and increment.
// Priority is Clr > Ld > Up; arithmetic wraps modulo 2^PCW.
module cu_pc #(
    parameter int PCW = 7
) (
    input  logic           Clk,
    input  logic           Clr,
    input  logic           Up,
    input  logic           Ld,
    input  logic [PCW-1:0] Ld_Val,
    output logic [PCW-1:0] PC
);

    // PC register update in priority order.
    always_ff @(posedge Clk) begin
        if (Clr)
            PC <= '0;
        else if (Ld)
            PC <= Ld_Val;
        else if (Up)
            PC <= PC + PCW'(1);
    end

endmodule

// File: rtl/control_unit_v2.sv
// Fetch/decode/execute controller for the 16-bit processor.
// Optional feature macro: CU_BRANCH_EN adds JMP/BRZ and the PC-load path;
// without it opcodes 6/7 execute as NOOP and Zero_Flag is ignored.
module control_unit_v2
    import cu_pkg::*;
#(
    parameter int IW  = 16,
    parameter int PCW = 7,
    parameter int DAW = 8,
    parameter int RAW = 4,
    parameter int ASW = 3
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [IW-1:0]  Instr_In,
    input  logic           Zero_Flag,
    output logic [PCW-1:0] PC_Out,
    output logic [IW-1:0]  IR_Out,
    output logic [DAW-1:0] D_Addr,
    output logic           D_Wr,
    output logic           RF_s,
    output logic [RAW-1:0] RF_W_Addr,
    output logic [RAW-1:0] RF_Ra_Addr,
    output logic [RAW-1:0] RF_Rb_Addr,
    output logic           RF_W_en,
    output logic [ASW-1:0] ALU_s0,
    output logic [3:0]     State_Out,
    output logic [3:0]     Next_State,
    output logic           Halted
);

    state_t         state;
    state_t         next_state;
    logic [IW-1:0]  ir;
    logic [3:0]     opcode;
    logic           pc_up;
    logic           pc_ld;
    logic [PCW-1:0] pc_ld_val;

    assign opcode     = ir[IW-1:IW-4];
    assign IR_Out     = ir;
    assign State_Out  = state;
    assign Next_State = next_state;

`ifdef CU_BRANCH_EN
    assign pc_ld_val = ir[PCW-1:0];
`else
    logic unused_zero_flag;
    assign unused_zero_flag = Zero_Flag;
    assign pc_ld_val = '0;
`endif

    cu_pc #(.PCW(PCW)) u_pc (
        .Clk    (Clk),
        .Clr    (Reset),
        .Up     (pc_up),
        .Ld     (pc_ld),
        .Ld_Val (pc_ld_val),
        .PC     (PC_Out)
    );

    // State register with synchronous reset to INIT.
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= INIT;
        else
            state <= next_state;
    end

    // Instruction register: captures memory read data during FETCH.
    always_ff @(posedge Clk) begin
        if (Reset)
            ir <= '0;
        else if (state == FETCH)
            ir <= Instr_In;
    end

    // Next-state and datapath-control decode of state plus IR.
    always_comb begin
        next_state = state;
        pc_up      = 1'b0;
        pc_ld      = 1'b0;
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = '0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        RF_W_en    = 1'b0;
        ALU_s0     = ASW'(ALU_PASS);
        Halted     = 1'b0;

        case (state)
            INIT: next_state = FETCH;
            FETCH: begin
                pc_up      = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_STORE: next_state = STORE;
                    OP_LOAD:  next_state = LOAD_A;
                    OP_ADD:   next_state = ADD;
                    OP_SUB:   next_state = SUB;
                    OP_HALT:  next_state = HALT;
`ifdef CU_BRANCH_EN
                    OP_JMP:   next_state = JMP;
                    OP_BRZ:   next_state = BRZ;
`endif
                    default:  next_state = NOOP;
                endcase
            end
            NOOP: next_state = FETCH;
            STORE: begin
                D_Addr     = ir[DAW+3:4];
                RF_Ra_Addr = RAW'(ir[3:0]);
                D_Wr       = 1'b1;
                next_state = FETCH;
            end
            LOAD_A: begin
                D_Addr     = ir[DAW+3:4];
                RF_s       = 1'b1;
                RF_W_Addr  = RAW'(ir[3:0]);
                next_state = LOAD_B;
            end
            LOAD_B: begin
                D_Addr     = ir[DAW+3:4];
                RF_s       = 1'b1;
                RF_W_Addr  = RAW'(ir[3:0]);
                RF_W_en    = 1'b1;
                next_state = FETCH;
            end
            ADD, SUB: begin
                RF_Ra_Addr = RAW'(ir[11:8]);
                RF_Rb_Addr = RAW'(ir[7:4]);
                RF_W_Addr  = RAW'(ir[3:0]);
                RF_W_en    = 1'b1;
                ALU_s0     = (state == ADD) ? ASW'(ALU_ADD) : ASW'(ALU_SUB);
                next_state = FETCH;
            end
            HALT: begin
                Halted     = 1'b1;
                next_state = HALT;
            end
`ifdef CU_BRANCH_EN
            JMP: begin
                pc_ld      = 1'b1;
                next_state = INIT;
            end
            BRZ: begin
                if (Zero_Flag) begin
                    pc_ld      = 1'b1;
                    next_state = INIT;
                end else begin
                    next_state = FETCH;
                end
            end
`endif
            default: next_state = INIT;
        endcase

        // Reset is synchronous, so the trace shows INIT as the true next state.
        if (Reset)
            next_state = INIT;
    end

endmodule

// File: tb/tb_control_unit_v2.sv
// Self-checking bench for control_unit_v2 with a synchronous instruction memory.
module tb_control_unit_v2;

    localparam logic [3:0] S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_NOOP = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4, S_LOAD_B = 4'd5, S_STORE = 4'd6, S_ADD = 4'd7;
    localparam logic [3:0] S_SUB = 4'd8, S_HALT = 4'd9, S_JMP = 4'd10, S_BRZ = 4'd11;
`ifdef CU_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [7:0]  da;
        logic        dwr;
        logic        rfs;
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        wen;
        logic [2:0]  alu;
        logic        hlt;
    } out_t;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic        zf;
        int unsigned cyc;
        out_t        exp;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Instr_In;
    logic        Zero_Flag = 1'b0;
    logic [6:0]  PC_Out;
    logic [15:0] IR_Out;
    logic [7:0]  D_Addr;
    logic        D_Wr, RF_s, RF_W_en, Halted;
    logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, State_Out, Next_State;
    logic [2:0]  ALU_s0;

    logic [15:0] mem [128];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    out_t        exp_q[$];
    logic        zf_q[$];
    vec_t        tbl[$];

    control_unit_v2 #(.IW(16), .PCW(7), .DAW(8), .RAW(4), .ASW(3)) dut (
        .Clk(Clk), .Reset(Reset), .Instr_In(Instr_In), .Zero_Flag(Zero_Flag),
        .PC_Out(PC_Out), .IR_Out(IR_Out), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
        .RF_W_Addr(RF_W_Addr), .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr),
        .RF_W_en(RF_W_en), .ALU_s0(ALU_s0), .State_Out(State_Out),
        .Next_State(Next_State), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge Clk) Instr_In <= mem[PC_Out];

    function automatic out_t mk(logic [3:0] st, logic [6:0] pc, logic [15:0] ir, logic [7:0] da,
                                logic dwr, logic rfs, logic [3:0] wa, logic [3:0] ra,
                                logic [3:0] rb, logic wen, logic [2:0] alu, logic hlt);
        return '{st, pc, ir, da, dwr, rfs, wa, ra, rb, wen, alu, hlt};
    endfunction

    function automatic out_t sample();
        return '{State_Out, PC_Out, IR_Out, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_Ra_Addr,
                 RF_Rb_Addr, RF_W_en, ALU_s0, Halted};
    endfunction

    task automatic chk(string nm, out_t got, out_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic chk_ns(string nm, logic [3:0] got, logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: Next_State got %0d expected %0d", nm, got, exp);
    endtask

    task automatic apply_reset(logic zf);
        Reset = 1'b1;
        Zero_Flag = zf;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic run_to(logic [15:0] w0, logic [15:0] w1, logic [15:0] w2, logic zf,
                          int unsigned cyc);
        for (int a = 0; a < 128; a++) mem[a] = 16'h0000;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
        mem[16] = 16'h3123;
        apply_reset(zf);
        repeat (cyc) step();
    endtask

    task automatic push(out_t o, logic z);
        exp_q.push_back(o);
        zf_q.push_back(z);
    endtask

    // Instruction-level reference: expands each instruction into its cycle trace.
    task automatic build_model(int unsigned n);
        logic [6:0]  p;
        logic [15:0] ir;
        logic        z;
        exp_q.delete();
        zf_q.delete();
        p = '0;
        ir = '0;
        push(mk(S_INIT, p, ir, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
        while (exp_q.size() < n) begin
            push(mk(S_FETCH, p, ir, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
            ir = mem[p];
            p = p + 7'd1;
            push(mk(S_DECODE, p, ir, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
            case (ir[15:12])
                4'd1: push(mk(S_STORE, p, ir, ir[11:4], 1, 0, 0, ir[3:0], 0, 0, 0, 0), 1'($urandom));
                4'd2: begin
                    push(mk(S_LOAD_A, p, ir, ir[11:4], 0, 1, ir[3:0], 0, 0, 0, 0, 0), 1'($urandom));
                    push(mk(S_LOAD_B, p, ir, ir[11:4], 0, 1, ir[3:0], 0, 0, 1, 0, 0), 1'($urandom));
                end
                4'd3: push(mk(S_ADD, p, ir, 0, 0, 0, ir[3:0], ir[11:8], ir[7:4], 1, 1, 0), 1'($urandom));
                4'd4: push(mk(S_SUB, p, ir, 0, 0, 0, ir[3:0], ir[11:8], ir[7:4], 1, 2, 0), 1'($urandom));
                4'd5: while (exp_q.size() < n)
                          push(mk(S_HALT, p, ir, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'($urandom));
                4'd6: begin
                    if (BR) begin
                        push(mk(S_JMP, p, ir, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                        p = ir[6:0];
                        push(mk(S_INIT, p, ir, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                    end else begin
                        push(mk(S_NOOP, p, ir, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                    end
                end
                4'd7: begin
                    if (BR) begin
                        z = 1'($urandom);
                        push(mk(S_BRZ, p, ir, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);
                        if (z) begin
                            p = ir[6:0];
                            push(mk(S_INIT, p, ir, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                        end
                    end else begin
                        push(mk(S_NOOP, p, ir, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                    end
                end
                default: push(mk(S_NOOP, p, ir, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
            endcase
        end
    endtask

    task automatic random_run(bit allow_halt, int unsigned n);
        logic [3:0] op;
        for (int a = 0; a < 128; a++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd5 && (!allow_halt || $urandom_range(0, 19) != 0)) op = 4'd3;
            mem[a] = {op, 12'($urandom)};
        end
        build_model(n);
        apply_reset(zf_q[0]);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                @(posedge Clk);
                #1 Zero_Flag = zf_q[i];
                #1;
            end
            chk("random_cycle", sample(), exp_q[i]);
            if (i + 1 < exp_q.size()) chk_ns("random_next", Next_State, exp_q[i+1].st);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl.push_back('{16'h2051, 16'h0000, 16'h5000, 1'b0, 0, mk(S_INIT,   0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h2051, 16'h0000, 16'h5000, 1'b0, 1, mk(S_FETCH,  0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h2051, 16'h0000, 16'h5000, 1'b0, 2, mk(S_DECODE, 1, 16'h2051, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h2051, 16'h0000, 16'h5000, 1'b0, 3, mk(S_LOAD_A, 1, 16'h2051, 8'h05, 0, 1, 1, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h2051, 16'h0000, 16'h5000, 1'b0, 4, mk(S_LOAD_B, 1, 16'h2051, 8'h05, 0, 1, 1, 0, 0, 1, 0, 0)});
        tbl.push_back('{16'h2051, 16'h0000, 16'h5000, 1'b0, 5, mk(S_FETCH,  1, 16'h2051, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h3123, 16'h4123, 16'h5000, 1'b0, 3, mk(S_ADD,    1, 16'h3123, 0, 0, 0, 3, 1, 2, 1, 1, 0)});
        tbl.push_back('{16'h3123, 16'h4123, 16'h5000, 1'b0, 6, mk(S_SUB,    2, 16'h4123, 0, 0, 0, 3, 1, 2, 1, 2, 0)});
        tbl.push_back('{16'h3123, 16'h4123, 16'h5000, 1'b0, 7, mk(S_FETCH,  2, 16'h4123, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h1A74, 16'h0000, 16'h5000, 1'b0, 3, mk(S_STORE,  1, 16'h1A74, 8'hA7, 1, 0, 0, 4, 0, 0, 0, 0)});
        tbl.push_back('{16'h1A74, 16'h0000, 16'h5000, 1'b0, 4, mk(S_FETCH,  1, 16'h1A74, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h0000, 16'h0000, 16'h5000, 1'b0, 9, mk(S_HALT,   3, 16'h5000, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{16'h0000, 16'h0000, 16'h5000, 1'b0, 29, mk(S_HALT,  3, 16'h5000, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{16'h7020, 16'h0000, 16'h5000, 1'b0, 5, mk(S_DECODE, 2, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
`ifdef CU_BRANCH_EN
        tbl.push_back('{16'h6010, 16'h0000, 16'h5000, 1'b0, 3, mk(S_JMP,    1, 16'h6010, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h6010, 16'h0000, 16'h5000, 1'b0, 4, mk(S_INIT,   7'h10, 16'h6010, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h6010, 16'h0000, 16'h5000, 1'b0, 6, mk(S_DECODE, 7'h11, 16'h3123, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h7020, 16'h0000, 16'h5000, 1'b0, 3, mk(S_BRZ,    1, 16'h7020, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h7020, 16'h0000, 16'h5000, 1'b1, 4, mk(S_INIT,   7'h20, 16'h7020, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
`else
        tbl.push_back('{16'h6010, 16'h0000, 16'h5000, 1'b0, 3, mk(S_NOOP,   1, 16'h6010, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h6010, 16'h0000, 16'h5000, 1'b0, 4, mk(S_FETCH,  1, 16'h6010, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{16'h7020, 16'h0000, 16'h5000, 1'b1, 4, mk(S_FETCH,  1, 16'h7020, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
`endif

        // Outputs while reset is still held.
        Reset = 1'b1;
        @(posedge Clk);
        #2 chk("during_reset", sample(), mk(S_INIT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_to(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].zf, tbl[i].cyc);
            chk($sformatf("vec%0d", i), sample(), tbl[i].exp);
        end

        // Reset asserted mid-LOAD_A.
        run_to(16'h2051, 16'h0000, 16'h5000, 1'b0, 3);
        chk("pre_reset_loada", sample(), mk(S_LOAD_A, 1, 16'h2051, 8'h05, 0, 1, 1, 0, 0, 0, 0, 0));
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        #1 chk("reset_from_loada", sample(), mk(S_INIT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset asserted while halted.
        run_to(16'h5000, 16'h0000, 16'h5000, 1'b0, 3);
        chk("pre_reset_halt", sample(), mk(S_HALT, 1, 16'h5000, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        #1 chk("reset_from_halt", sample(), mk(S_INIT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int r = 0; r < 4; r++) random_run(1'b1, 300);
        random_run(1'b0, 700);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_unit_v2.md
Name: control_unit_v2

Overview:
- Parametrised successor to the 16-bit processor's fetch/decode/execute controller.
- Sequences the PC, instruction register and datapath control (data memory, register file, ALU select) for the opcode set NOOP/STORE/LOAD/ADD/SUB/HALT.
- Adds jump/branch, a halt indicator and a per-cycle state trace.
- Instruction memory is external, synchronous, with 1-cycle read latency; this block drives its address and receives its data.

Parameters:
IW, 16, instruction width; opcode is IR[IW-1:IW-4].
PCW, 7, PC/instruction-address width.
DAW, 8, data-memory address width; the field is IR[DAW+3:4].
RAW, 4, register-file address width.
ASW, 3, ALU select width.

Ports:
Clk  in  1  single system clock, rising edge.
Reset  in  1  synchronous, active-high reset.
Instr_In  in  IW  instruction-memory read data, valid one cycle after PC_Out changes.
Zero_Flag  in  1  ALU zero flag, sampled in BRZ.
PC_Out  out  PCW  program counter, drives the instruction-memory address.
IR_Out  out  IW  instruction register.
D_Addr  out  DAW  data-memory address.
D_Wr  out  1  data-memory write enable.
RF_s  out  1  register-file write mux select (1 = memory, 0 = ALU).
RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr  out  RAW  register-file write and read addresses.
RF_W_en  out  1  register-file write enable.
ALU_s0  out  ASW  ALU op select (0 = pass, 1 = add, 2 = sub).
State_Out, Next_State  out  4  current and next FSM state encodings.
Halted  out  1  high while in HALT.

Behaviour:
- Reset is sampled at the clock edge. From any state, mid-instruction included: state=INIT, PC=0, IR=0, all control outputs 0, Halted=0.
- All datapath controls are combinational decodes of state plus IR and default to 0 in every state not listed below.
- INIT: PC held. Next cycle is FETCH, by which point Instr_In = mem[PC].
- FETCH: IR <= Instr_In; PC <= PC+1, wrapping from 2^PCW-1 to 0. Next cycle is DECODE.
- DECODE: branch on opcode:
  - 0 -> NOOP
  - 1 -> STORE
  - 2 -> LOAD_A
  - 3 -> ADD
  - 4 -> SUB
  - 5 -> HALT
  - 6 -> JMP
  - 7 -> BRZ
  - 8-15 -> NOOP (illegal opcodes execute as NOOP)
- NOOP -> FETCH.
- STORE: D_Addr = IR[DAW+3:4], RF_Ra_Addr = IR[3:0], D_Wr = 1 for exactly one cycle. Then FETCH.
- LOAD_A: D_Addr = IR[DAW+3:4], RF_s = 1, RF_W_Addr = IR[3:0]. Then LOAD_B.
- LOAD_B: same outputs as LOAD_A plus RF_W_en = 1. Then FETCH. Load latency is 2 cycles.
- ADD/SUB: RF_Ra_Addr = IR[11:8], RF_Rb_Addr = IR[7:4], RF_W_Addr = IR[3:0], RF_W_en = 1, RF_s = 0, ALU_s0 = 1 (ADD) or 2 (SUB). Then FETCH.
- HALT: Halted = 1, PC frozen, stays in HALT until Reset.
- JMP: PC <= IR[PCW-1:0]. Next state is INIT, a one-cycle refetch bubble that covers instruction-memory latency.
- BRZ: if Zero_Flag = 1, PC <= IR[PCW-1:0] and next state is INIT. Otherwise PC unchanged and next state is FETCH.
- Cycle cost per instruction type: NOOP, ADD, SUB, STORE take 3 cycles. LOAD takes 4 cycles. Taken jump/branch takes 4 cycles including the bubble.
- Widths:
  - Fields narrower than their port are zero-extended.
  - The jump target is truncated to PCW.
  - PC arithmetic is modulo 2^PCW.

Optional Feature:
- Macro: CU_BRANCH_EN.
- Defined: JMP/BRZ states and PC-load path present, as above.
- Undefined: opcodes 6 and 7 decode to NOOP. The PC-load path and the JMP/BRZ states are absent. The Zero_Flag port stays but is ignored.

Decomposition:
- Package cu_pkg holds:
  - state_t enum: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9, JMP=10, BRZ=11.
  - Opcode localparams OP_NOOP..OP_BRZ.
  - ALU select constants ALU_PASS/ALU_ADD/ALU_SUB.
- One sub-module, cu_pc: the PCW-wide program counter with Clr, Up, Ld and Ld_Val. Priority is Clr > Ld > Up.

Test Plan:
- Reset held 2 cycles, then released -> State_Out: INIT, FETCH, DECODE. PC_Out goes 0 -> 1 after FETCH. All control outputs 0 during reset.
- mem[0]=0x2051 (LOAD d[0x05]->R1) -> LOAD_A then LOAD_B. D_Addr=0x05, RF_s=1, RF_W_Addr=1. RF_W_en high only in LOAD_B.
- mem[0]=0x3123 (ADD R1+R2->R3), mem[1]=0x4123 (SUB) -> ALU_s0 = 1 then 2. RF_W_en=1 for one cycle each. 6 cycles from the first FETCH to the third FETCH.
- mem[0]=0x1A74 (STORE R4->d[0xA7]) -> D_Wr pulses for exactly one cycle with D_Addr=0xA7, RF_Ra_Addr=4.
- CU_BRANCH_EN defined, mem[0]=0x6010 (JMP 0x10) -> PC_Out=0x10, then INIT, then IR=mem[0x10]. BRZ with Zero_Flag=0 -> PC=2, no bubble. Undefined -> treated as NOOP, PC=1.
- mem[2]=0x5000 (HALT) -> Halted=1, PC frozen for 20 cycles. Reset asserted in HALT or mid-LOAD_A -> INIT, PC=0, Halted=0 the next cycle.
